// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_unit
// Brief    : Fetch-stage program counter with next-PC selection for
//            sequential, J/JAL, BEQ/BNE and JR/JALR flow. Supports an
//            optional branch-delay slot, a stall input and a circular
//            return-address stack that is pushed on link and popped on return.
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_unit #(
  parameter int            AW         = 32,
  parameter logic [AW-1:0] RESET_PC   = '0,
  parameter int            RAS_DEPTH  = 4,
  parameter int            DELAY_SLOT = 0
) (
  input  logic          clk,
  input  logic          rst,        // asynchronous, active-low
  input  logic          en,
  input  logic [31:0]   instr,
  input  logic [AW-1:0] rs_val,
  input  logic          br_taken,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_plus4,
  output logic [AW-1:0] link_addr,
  output logic          redirect,
  output logic [AW-1:0] ras_top,
  output logic          ras_empty,
  output logic          ras_full,
  output logic          ras_ovf
);

  localparam int          PW      = $clog2(RAS_DEPTH);
  localparam logic [PW:0] C_DEPTH = (PW+1)'(RAS_DEPTH);

  typedef enum logic {ST_IDLE = 1'b0, ST_PENDING = 1'b1} state_e;

  // Registered state
  logic [AW-1:0] pc_q, pc_d;
  logic          redirect_q, redirect_d;
  logic [AW-1:0] tgt_q, tgt_d;
  state_e        state_q, state_d;
  logic [AW-1:0] ras_mem_q [RAS_DEPTH];
  logic [AW-1:0] ras_mem_d [RAS_DEPTH];
  logic [PW-1:0] ras_ptr_q, ras_ptr_d;
  logic [PW:0]   ras_cnt_q, ras_cnt_d;
  logic [AW-1:0] ras_top_q, ras_top_d;
  logic          ras_ovf_q, ras_ovf_d;

  // Decode
  logic [5:0]    opcode, funct;
  logic          is_j, is_jal, is_br, is_jr, is_jalr, xfer;
  logic          do_push, do_pop, accept;
  logic [AW-1:0] j_target, br_target, jr_target, target;
  logic          unused_bits;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign is_j     = (opcode == 6'b000010);
  assign is_jal   = (opcode == 6'b000011);
  assign is_br    = (opcode == 6'b000100) || (opcode == 6'b000101);
  assign is_jr    = (opcode == 6'b000000) && (funct == 6'b001000);
  assign is_jalr  = (opcode == 6'b000000) && (funct == 6'b001001);
  assign xfer     = is_j || is_jal || (is_br && br_taken) || is_jr || is_jalr;

  assign pc_plus4  = pc_q + AW'(4);
  assign link_addr = pc_q + ((DELAY_SLOT != 0) ? AW'(8) : AW'(4));

  // The region bits above bit 27 only exist when AW is wider than 28
  if (AW > 28) begin : g_jtgt_region
    assign j_target = {pc_plus4[AW-1:28], instr[25:0], 2'b00};
  end else begin : g_jtgt_flat
    assign j_target = {instr[25:0], 2'b00};
  end

  assign br_target = pc_plus4 + {{(AW-18){instr[15]}}, instr[15:0], 2'b00};
  assign jr_target = {rs_val[AW-1:2], 2'b00};
  assign target    = (is_j || is_jal)    ? j_target  :
                     (is_jr || is_jalr)  ? jr_target : br_target;

  // Delay-slot instructions never decode as transfers, so RAS effects are gated too
  assign accept  = en && !((DELAY_SLOT != 0) && (state_q == ST_PENDING));
  assign do_push = accept && (is_jal || (is_jalr && instr[15:11] == 5'd31));
  assign do_pop  = accept && ((is_jr || is_jalr) && instr[25:21] == 5'd31);

  assign unused_bits = ^{instr[20:16], instr[10:6], rs_val[1:0]};

  // Next-state computation for pc, delay-slot FSM and RAS
  always_comb begin
    pc_d       = pc_q;
    redirect_d = redirect_q;
    tgt_d      = tgt_q;
    state_d    = state_q;
    ras_mem_d  = ras_mem_q;
    ras_ptr_d  = ras_ptr_q;
    ras_cnt_d  = ras_cnt_q;
    ras_ovf_d  = ras_ovf_q;
    ras_top_d  = ras_top_q;

    if (en) begin
      if (DELAY_SLOT == 0) begin
        pc_d       = xfer ? target : pc_plus4;
        redirect_d = xfer;
      end else if (state_q == ST_IDLE) begin
        pc_d       = pc_plus4;
        redirect_d = 1'b0;
        if (xfer) begin
          tgt_d   = target;
          state_d = ST_PENDING;
        end
      end else begin
        pc_d       = tgt_q;
        redirect_d = 1'b1;
        state_d    = ST_IDLE;
      end

      // Pop first so a JALR with rs=rd=31 replaces the top entry in place
      if (do_pop && ras_cnt_d != '0) begin
        ras_ptr_d = ras_ptr_d - 1'b1;
        ras_cnt_d = ras_cnt_d - 1'b1;
      end
      if (do_push) begin
        ras_ptr_d            = ras_ptr_d + 1'b1;
        ras_mem_d[ras_ptr_d] = link_addr;
        if (ras_cnt_d == C_DEPTH) ras_ovf_d = 1'b1;
        else                      ras_cnt_d = ras_cnt_d + 1'b1;
      end
      ras_top_d = (ras_cnt_d != '0) ? ras_mem_d[ras_ptr_d] : '0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      tgt_q      <= '0;
      state_q    <= ST_IDLE;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem_q[i] <= '0;
      ras_ptr_q  <= '0;
      ras_cnt_q  <= '0;
      ras_top_q  <= '0;
      ras_ovf_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      tgt_q      <= tgt_d;
      state_q    <= state_d;
      ras_mem_q  <= ras_mem_d;
      ras_ptr_q  <= ras_ptr_d;
      ras_cnt_q  <= ras_cnt_d;
      ras_top_q  <= ras_top_d;
      ras_ovf_q  <= ras_ovf_d;
    end
  end

  assign pc        = pc_q;
  assign redirect  = redirect_q;
  assign ras_top   = ras_top_q;
  assign ras_empty = (ras_cnt_q == '0);
  assign ras_full  = (ras_cnt_q == C_DEPTH);
  assign ras_ovf   = ras_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_next_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_next_unit
// Brief    : Directed testbench for pc_next_unit; one instance without and
//            one with the branch-delay slot.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en0 = 1'b1, en1 = 1'b1;
  logic [31:0] instr0 = '0, instr1 = '0;
  logic [31:0] rs0 = '0, rs1 = '0;
  logic        br0 = 1'b0, br1 = 1'b0;

  logic [31:0] pc0, pp4_0, link0, top0, pc1, pp4_1, link1, top1;
  logic        red0, emp0, full0, ovf0, red1, emp1, full1, ovf1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_next_unit #(.AW(32), .RESET_PC(32'h0), .RAS_DEPTH(4), .DELAY_SLOT(0)) dut0 (
    .clk(clk), .rst(rst), .en(en0), .instr(instr0), .rs_val(rs0), .br_taken(br0),
    .pc(pc0), .pc_plus4(pp4_0), .link_addr(link0), .redirect(red0),
    .ras_top(top0), .ras_empty(emp0), .ras_full(full0), .ras_ovf(ovf0));

  pc_next_unit #(.AW(32), .RESET_PC(32'h1000), .RAS_DEPTH(4), .DELAY_SLOT(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .instr(instr1), .rs_val(rs1), .br_taken(br1),
    .pc(pc1), .pc_plus4(pp4_1), .link_addr(link1), .redirect(red1),
    .ras_top(top1), .ras_empty(emp1), .ras_full(full1), .ras_ovf(ovf1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] f_j(input logic [25:0] f);   return {6'b000010, f}; endfunction
  function automatic logic [31:0] f_jal(input logic [25:0] f); return {6'b000011, f}; endfunction
  function automatic logic [31:0] f_beq(input logic [15:0] i); return {6'b000100, 5'd1, 5'd2, i}; endfunction
  function automatic logic [31:0] f_bne(input logic [15:0] i); return {6'b000101, 5'd1, 5'd2, i}; endfunction
  function automatic logic [31:0] f_jr(input logic [4:0] rs);  return {6'd0, rs, 15'd0, 6'b001000}; endfunction
  function automatic logic [31:0] f_jalr(input logic [4:0] rs, input logic [4:0] rd);
    return {6'd0, rs, 5'd0, rd, 5'd0, 6'b001001};
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic        br;
    logic [31:0] exp_pc;
    logic        exp_red;
    logic [31:0] exp_top;
    logic        exp_empty;
  } vec_t;

  vec_t vec [19];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input logic [31:0] ins, input logic [31:0] rv, input logic e);
    instr1 = ins; rs1 = rv; en1 = e;
    tick();
  endtask

  logic [31:0] links [5];
  logic [31:0] pops  [5];

  initial begin
    // DELAY_SLOT=0 directed vectors: inputs apply at the current pc, expectations after the edge
    vec[0]  = '{32'h0,              32'h0,        1'b0, 32'h4,        1'b0, 32'h0,   1'b1};
    vec[1]  = '{32'h0,              32'h0,        1'b0, 32'h8,        1'b0, 32'h0,   1'b1};
    vec[2]  = '{32'h0,              32'h0,        1'b0, 32'hC,        1'b0, 32'h0,   1'b1};
    vec[3]  = '{f_jr(5'd1),         32'h00400013, 1'b0, 32'h00400010, 1'b1, 32'h0,   1'b1};
    vec[4]  = '{f_j(26'h0100000),   32'h0,        1'b0, 32'h00400000, 1'b1, 32'h0,   1'b1};
    vec[5]  = '{32'h0,              32'h0,        1'b0, 32'h00400004, 1'b0, 32'h0,   1'b1};
    vec[6]  = '{f_jr(5'd1),         32'h100,      1'b0, 32'h100,      1'b1, 32'h0,   1'b1};
    vec[7]  = '{f_beq(16'hFFFE),    32'h0,        1'b1, 32'h0FC,      1'b1, 32'h0,   1'b1};
    vec[8]  = '{f_jr(5'd1),         32'h100,      1'b0, 32'h100,      1'b1, 32'h0,   1'b1};
    vec[9]  = '{f_beq(16'hFFFE),    32'h0,        1'b0, 32'h104,      1'b0, 32'h0,   1'b1};
    vec[10] = '{f_bne(16'h0010),    32'h0,        1'b1, 32'h148,      1'b1, 32'h0,   1'b1};
    vec[11] = '{f_jal(26'h40),      32'h0,        1'b0, 32'h100,      1'b1, 32'h14C, 1'b0};
    vec[12] = '{f_jalr(5'd2,5'd31), 32'h300,      1'b0, 32'h300,      1'b1, 32'h104, 1'b0};
    vec[13] = '{f_jalr(5'd31,5'd31),32'h500,      1'b0, 32'h500,      1'b1, 32'h304, 1'b0};
    vec[14] = '{f_jr(5'd31),        32'h104,      1'b0, 32'h104,      1'b1, 32'h14C, 1'b0};
    vec[15] = '{f_jr(5'd31),        32'h14C,      1'b0, 32'h14C,      1'b1, 32'h0,   1'b1};
    vec[16] = '{f_jr(5'd31),        32'h40,       1'b0, 32'h40,       1'b1, 32'h0,   1'b1};
    vec[17] = '{f_jr(5'd1),         32'hF0000000, 1'b0, 32'hF0000000, 1'b1, 32'h0,   1'b1};
    vec[18] = '{f_j(26'h10),        32'h0,        1'b0, 32'hF0000040, 1'b1, 32'h0,   1'b1};

    links[0] = 32'hF0000044; links[1] = 32'hF0000404; links[2] = 32'hF0000804;
    links[3] = 32'hF0000C04; links[4] = 32'hF0001004;
    pops[0] = 32'hF0000C04; pops[1] = 32'hF0000804; pops[2] = 32'hF0000404;
    pops[3] = 32'h0;        pops[4] = 32'h0;

    // Reset, release between edges
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_pc0", pc0, 32'h0);
    chk("rst_red0", {31'd0, red0}, 32'd0);
    chk("rst_empty0", {31'd0, emp0}, 32'd1);
    chk("rst_full0", {31'd0, full0}, 32'd0);
    chk("rst_ovf0", {31'd0, ovf0}, 32'd0);
    chk("rst_top0", top0, 32'h0);
    chk("rst_pc1", pc1, 32'h1000);

    // Table-driven DELAY_SLOT=0 sequence
    for (int i = 0; i < 19; i++) begin
      instr0 = vec[i].instr; rs0 = vec[i].rs; br0 = vec[i].br;
      tick();
      chk($sformatf("v%0d_pc", i), pc0, vec[i].exp_pc);
      chk($sformatf("v%0d_red", i), {31'd0, red0}, {31'd0, vec[i].exp_red});
      chk($sformatf("v%0d_top", i), top0, vec[i].exp_top);
      chk($sformatf("v%0d_empty", i), {31'd0, emp0}, {31'd0, vec[i].exp_empty});
      chk($sformatf("v%0d_pp4", i), pp4_0, vec[i].exp_pc + 32'd4);
      chk($sformatf("v%0d_link", i), link0, vec[i].exp_pc + 32'd4);
    end

    // Five JALs overflow a 4-deep RAS
    for (int i = 0; i < 5; i++) begin
      instr0 = f_jal(26'((i + 1) * 32'h100)); br0 = 1'b0;
      tick();
      chk($sformatf("jal%0d_pc", i), pc0, 32'hF0000000 + (i + 1) * 32'h400);
      chk($sformatf("jal%0d_top", i), top0, links[i]);
      chk($sformatf("jal%0d_full", i), {31'd0, full0}, (i >= 3) ? 32'd1 : 32'd0);
      chk($sformatf("jal%0d_ovf", i), {31'd0, ovf0}, (i == 4) ? 32'd1 : 32'd0);
    end
    // Five returns: fourth empties the stack, fifth is a no-op
    for (int i = 0; i < 5; i++) begin
      instr0 = f_jr(5'd31); rs0 = 32'h500;
      tick();
      chk($sformatf("ret%0d_top", i), top0, pops[i]);
      chk($sformatf("ret%0d_empty", i), {31'd0, emp0}, (i >= 3) ? 32'd1 : 32'd0);
      chk($sformatf("ret%0d_full", i), {31'd0, full0}, 32'd0);
      chk($sformatf("ret%0d_ovf", i), {31'd0, ovf0}, 32'd1);
    end
    instr0 = '0;

    // DELAY_SLOT=1: move to 0x200 via JR + delay slot
    step1(f_jr(5'd1), 32'h200, 1'b1);
    chk("ds_jr_red", {31'd0, red1}, 32'd0);
    step1(32'h0, 32'h0, 1'b1);
    chk("ds_at200_pc", pc1, 32'h200);
    chk("ds_at200_red", {31'd0, red1}, 32'd1);
    // JAL at 0x200: delay slot first, then target; link is pc+8
    step1(f_jal(26'h100), 32'h0, 1'b1);
    chk("ds_jal_pc", pc1, 32'h204);
    chk("ds_jal_red", {31'd0, red1}, 32'd0);
    chk("ds_jal_top", top1, 32'h208);
    chk("ds_jal_link", link1, 32'h20C);
    step1(32'h0, 32'h0, 1'b1);
    chk("ds_jal_tgt", pc1, 32'h400);
    chk("ds_jal_tgt_red", {31'd0, red1}, 32'd1);
    // JR $31 with a J in its delay slot: the J is ignored
    step1(f_jr(5'd31), 32'h208, 1'b1);
    chk("ds_jr31_pc", pc1, 32'h404);
    chk("ds_jr31_empty", {31'd0, emp1}, 32'd1);
    step1(f_j(26'h200), 32'h0, 1'b1);
    chk("ds_jr31_tgt", pc1, 32'h208);
    chk("ds_jr31_red", {31'd0, red1}, 32'd1);
    // Stall while pending
    step1(f_jal(26'h300), 32'h0, 1'b1);
    chk("ds_jal2_pc", pc1, 32'h20C);
    chk("ds_jal2_top", top1, 32'h210);
    for (int i = 0; i < 3; i++) begin
      step1(f_jal(26'h111), 32'h0, 1'b0);
      chk($sformatf("stall%0d_pc", i), pc1, 32'h20C);
      chk($sformatf("stall%0d_red", i), {31'd0, red1}, 32'd0);
      chk($sformatf("stall%0d_top", i), top1, 32'h210);
    end
    // Delay-slot JAL is suppressed, including its push
    step1(f_jal(26'h111), 32'h0, 1'b1);
    chk("unstall_pc", pc1, 32'hC00);
    chk("unstall_red", {31'd0, red1}, 32'd1);
    chk("unstall_top", top1, 32'h210);
    step1(32'h0, 32'h0, 1'b1);
    chk("after_tgt_pc", pc1, 32'hC04);
    chk("after_tgt_red", {31'd0, red1}, 32'd0);
    // Reset mid-PENDING discards the target
    step1(f_jal(26'h40), 32'h0, 1'b1);
    chk("pend_pc", pc1, 32'hC08);
    instr1 = '0;
    #2 rst = 1'b0;
    #1;
    chk("midrst_pc1", pc1, 32'h1000);
    chk("midrst_empty1", {31'd0, emp1}, 32'd1);
    chk("midrst_top1", top1, 32'h0);
    chk("midrst_pc0", pc0, 32'h0);
    #2 rst = 1'b1;
    step1(32'h0, 32'h0, 1'b1);
    chk("postrst_pc", pc1, 32'h1004);
    chk("postrst_red", {31'd0, red1}, 32'd0);
    step1(32'h0, 32'h0, 1'b1);
    chk("postrst_pc2", pc1, 32'h1008);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Parametrised program-counter register with next-PC selection for the MIPS-style fetch stage.
- Supersedes the single-purpose jump block. Handles sequential, J/JAL, taken BEQ/BNE and JR/JALR redirects.
- Adds an optional one-instruction branch-delay slot, a stall input, and a small circular return-address stack (RAS) that is pushed on link and popped on return.
- Sits between the instruction memory output and the fetch address.

Parameters:
- AW, 32, PC width; must be at least 28.
- RESET_PC, 0, PC value loaded on reset.
- RAS_DEPTH, 4, number of RAS entries; power of two, 2 to 16.
- DELAY_SLOT, 0, 1 = redirect takes effect after one delay-slot instruction; 0 = redirect takes effect on the next cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  advance enable; 0 = stall, all state holds.
- instr  in  32  instruction fetched at the current pc.
- rs_val  in  AW  register rs value, used for JR/JALR.
- br_taken  in  1  branch condition result for BEQ/BNE at the current pc.
- pc  out  AW  current fetch address.
- pc_plus4  out  AW  pc+4, combinational.
- link_addr  out  AW  return address for JAL/JALR, combinational.
- redirect  out  1  registered; 1 for one accepted cycle when pc was loaded from a non-sequential target.
- ras_top  out  AW  top RAS entry; 0 when empty.
- ras_empty  out  1  RAS holds no entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_ovf  out  1  sticky; set when a push occurs while full.

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC, redirect=0, RAS count=0, ras_empty=1, ras_full=0, ras_ovf=0, ras_top=0, pending redirect cleared.
- Reset mid-operation discards any pending delay-slot target.
- All updates occur on the rising clk edge with en=1. With en=0, every register holds and redirect holds its value.
- Decode (opcode = instr[31:26]):
  - 000010 is J.
  - 000011 is JAL.
  - 000100 and 000101 are branches; the branch is taken only if br_taken=1.
  - 000000 with funct 001000 is JR; 000000 with funct 001001 is JALR.
  - Anything else is sequential.
- Target computation, all arithmetic modulo 2^AW:
  - J/JAL: {pc_plus4[AW-1:28], instr[25:0], 2'b00}.
  - Branch: pc_plus4 + (sign-extended instr[15:0] shifted left 2).
  - JR/JALR: {rs_val[AW-1:2], 2'b00}; the low bits are forced to 0.
- link_addr = pc+8 when DELAY_SLOT=1, else pc+4.
- DELAY_SLOT=0:
  - Next pc = target if a transfer is decoded, else pc_plus4.
  - redirect=1 on the cycle pc holds a target.
- DELAY_SLOT=1, two states, IDLE and PENDING:
  - IDLE, transfer decoded: pc←pc_plus4, latch target, go to PENDING.
  - PENDING: pc←latched target, redirect=1, go to IDLE.
  - The instruction at the delay slot is not decoded for control transfer; the pending target wins.
  - RAS side effects of a transfer in the delay slot are also suppressed.
  - Stall while PENDING holds both state and the latched target.
- RAS push: on an accepted JAL, or on JALR with rd=instr[15:11]=31, push link_addr.
  - Push when full: overwrite the oldest entry (circular), count stays at RAS_DEPTH, ras_ovf←1.
- RAS pop: on an accepted JR with rs=instr[25:21]=31, pop.
  - Pop when empty: no-op, no flag change.
- A JALR that both pushes and pops (rs=31 and rd=31) performs a pop then a push. The net count is unchanged and the top is replaced with link_addr.
- ras_top, ras_empty and ras_full are registered views of the stack state after the edge.
- The RAS is advisory only; JR targets always use rs_val.

Test Plan:
- Reset release, DELAY_SLOT=0, en=1, instr=NOP for 3 cycles -> pc goes 0, 4, 8, 12; redirect=0; ras_empty=1.
- pc=0x00400010, instr=J with target field 0x0100000 -> next pc=0x00400000 (upper bits 0x0 from pc_plus4, low bits 0x0400000); redirect=1 for one cycle.
- BEQ at pc=0x100 with imm=0xFFFE, br_taken=1 -> pc=0x0FC.
  - Same instruction with br_taken=0 -> pc=0x104.
- DELAY_SLOT=1, JAL at pc=0x200 -> pc=0x204, then the target. ras_top=0x208.
  - Then a J in the delay slot of a following JR $31 -> that J is ignored and pc = rs_val.
- RAS_DEPTH=4: five JALs -> ras_full=1, ras_ovf=1, and ras_top = the fifth link address.
  - Then five JR $31 -> the fourth pop sets ras_empty=1; the fifth pop is a no-op.
- en=0 for 3 cycles while in PENDING -> pc, the latched target and the RAS all hold; after en=1, pc equals the target on the next edge.
  - Asserting rst=0 mid-PENDING -> pc=RESET_PC immediately, and no target is applied after release.
